// File: rtl/ifft_overlap_add.sv
// rtl/ifft_overlap_add.sv - IFFT frame normaliser, 50% overlap-add and audio-rate hop playback
//
// Purpose:
//   Takes one N-sample real IFFT output frame and restores its block exponent.
//   It overlap-adds the first half of the frame with the tail of the previous
//   frame and stores the result into the free play bank. It keeps the second
//   half as the new tail. The finished hop is played one sample per
//   sample_tick from the other bank.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-low; clears all state
//   frame_valid    in   one IFFT output sample present this cycle
//   frame_data     in   NB-bit signed real IFFT sample
//   frame_scaling  in   4-bit block exponent, taken with the first sample of a frame
//   frame_ready    out  fill bank free; a new frame may start (registered)
//   sample_tick    in   one-cycle audio-rate strobe
//   audio_out      out  OUT_W-bit signed audio sample (registered)
//   audio_valid    out  one-cycle pulse when audio_out is updated
//   underrun       out  sticky; playback emitted a silence sample at least once
//   drop_err       out  sticky; frame_valid arrived while no frame could be accepted
//
// Build option:
//   OLA_UNDERRUN_HOLD_EN defined -> a starved tick repeats the last audio_out value.
//   Undefined (default)          -> a starved tick outputs 0.

module ifft_overlap_add #(
  parameter int N          = 512,
  parameter int LOG_N      = 9,
  parameter int HOP        = 256,
  parameter int NB         = 18,
  parameter int OUT_W      = 16,
  parameter int NORM_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [NB-1:0]    frame_data,
  input  logic [3:0]       frame_scaling,
  output logic             frame_ready,
  input  logic             sample_tick,
  output logic [OUT_W-1:0] audio_out,
  output logic             audio_valid,
  output logic             underrun,
  output logic             drop_err
);

  // Intermediate is wide enough for an NB-bit sample shifted left by up to 15.
  localparam int IW = NB + 15;
  localparam int RW = LOG_N - 1;
  localparam logic [LOG_N-1:0] K_LAST = LOG_N'(N - 1);
  localparam logic [RW-1:0]    R_LAST = RW'(HOP - 1);
  localparam logic [RW-1:0]    R_ONE  = RW'(1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_FULL
  } wstate_t;

  // Write side state
  wstate_t          state_q;
  logic [LOG_N-1:0] k_q;
  logic [3:0]       scale_q;
  logic             frame_ready_q;
  logic             drop_err_q;

  // Playback side state
  logic             play_b_q;
  logic [RW-1:0]    r_q;
  logic             starved_q;
  logic [OUT_W-1:0] audio_out_q;
  logic             audio_valid_q;
  logic             underrun_q;

  // Storage: two play banks and the overlap tail
  logic [NB-1:0] bank_q [0:1][0:HOP-1];
  logic [NB-1:0] tail_q [0:HOP-1];

  // Control
  logic          full_w;
  logic          accept_w;
  logic          drop_w;
  logic          swap_w;
  logic          fill_b_w;
  logic          wr_tail_w;
  logic [RW-1:0] wr_idx_w;
  logic [3:0]    wr_scale_w;

  // Datapath
  logic signed [IW-1:0]    ext_w;
  logic signed [IW-1:0]    shl_w;
  logic signed [IW-1:0]    shr_w;
  logic        [NB-1:0]    norm_w;
  logic        [NB-1:0]    tail_rd_w;
  logic        [NB:0]      sum_w;
  logic        [NB-1:0]    fill_w;
  logic                    rd_bank_w;
  logic        [RW-1:0]    rd_idx_w;
  logic signed [NB-1:0]    rd_w;
  logic signed [NB-1:0]    rd_shr_w;
  logic        [OUT_W-1:0] out_w;
  logic        [OUT_W-1:0] silence_w;

  assign full_w   = (state_q == W_FULL);
  assign accept_w = frame_valid &&
                    (((state_q == W_IDLE) && frame_ready_q) || (state_q == W_FILL));
  assign drop_w   = frame_valid &&
                    (full_w || ((state_q == W_IDLE) && !frame_ready_q));

  // A swap happens on a tick that finishes the current hop (or finds us starved)
  // while the fill bank is complete; it also releases the write side.
  assign swap_w   = sample_tick && full_w && (starved_q || (r_q == R_LAST));

  // The bank being filled is always the one not being played.
  assign fill_b_w   = ~play_b_q;
  // k_q is zero in W_IDLE, so sample 0 lands at index 0 without a special case.
  assign wr_tail_w  = k_q[LOG_N-1];
  assign wr_idx_w   = k_q[RW-1:0];
  // The exponent is taken from the port with sample 0, from the latch afterwards.
  assign wr_scale_w = (state_q == W_IDLE) ? frame_scaling : scale_q;

  // Exponent restore and fixed normalisation shift
  assign ext_w = {{(IW-NB){frame_data[NB-1]}}, frame_data};
  assign shl_w = ext_w <<< wr_scale_w;
  assign shr_w = shl_w >>> NORM_SHIFT;

  always_comb begin
    norm_w = shr_w[NB-1:0];
    if (shr_w[IW-1] && !(&shr_w[IW-2:NB-1])) begin
      norm_w = {1'b1, {(NB-1){1'b0}}};
    end else if (!shr_w[IW-1] && (|shr_w[IW-2:NB-1])) begin
      norm_w = {1'b0, {(NB-1){1'b1}}};
    end
  end

  // Overlap-add against the stored tail, one guard bit then saturate.
  assign tail_rd_w = tail_q[wr_idx_w];
  assign sum_w     = {tail_rd_w[NB-1], tail_rd_w} + {norm_w[NB-1], norm_w};

  always_comb begin
    fill_w = sum_w[NB-1:0];
    if (sum_w[NB] != sum_w[NB-1]) begin
      fill_w = sum_w[NB] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
    end
  end

  // A starved tick that swaps plays index 0 of the incoming bank immediately.
  assign rd_bank_w = starved_q ? ~play_b_q : play_b_q;
  assign rd_idx_w  = starved_q ? '0 : r_q;
  assign rd_w      = bank_q[rd_bank_w][rd_idx_w];
  assign rd_shr_w  = rd_w >>> (NB - OUT_W);

  always_comb begin
    out_w = rd_shr_w[OUT_W-1:0];
    if (rd_shr_w[NB-1] && !(&rd_shr_w[NB-2:OUT_W-1])) begin
      out_w = {1'b1, {(OUT_W-1){1'b0}}};
    end else if (!rd_shr_w[NB-1] && (|rd_shr_w[NB-2:OUT_W-1])) begin
      out_w = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

`ifdef OLA_UNDERRUN_HOLD_EN
  assign silence_w = audio_out_q;
`else
  assign silence_w = '0;
`endif

  // Write FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= W_IDLE;
      k_q           <= '0;
      scale_q       <= '0;
      frame_ready_q <= 1'b1;
      drop_err_q    <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (accept_w) begin
            scale_q       <= frame_scaling;
            k_q           <= LOG_N'(1);
            state_q       <= W_FILL;
            frame_ready_q <= 1'b0;
          end
        end
        W_FILL: begin
          if (accept_w) begin
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= W_FULL;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        W_FULL: begin
          if (swap_w) begin
            state_q       <= W_IDLE;
            frame_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= W_IDLE;
          k_q           <= '0;
          frame_ready_q <= 1'b1;
        end
      endcase
      if (drop_w) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  // Play banks carry no reset: nothing is read from a bank before it is filled.
  always_ff @(posedge clk) begin
    if (accept_w && !wr_tail_w) begin
      bank_q[fill_b_w][wr_idx_w] <= fill_w;
    end
  end

  // The tail is cleared on reset so the first frame after reset overlaps with silence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < HOP; i++) begin
        tail_q[i] <= '0;
      end
    end else if (accept_w && wr_tail_w) begin
      tail_q[wr_idx_w] <= norm_w;
    end
  end

  // Playback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      play_b_q      <= 1'b0;
      r_q           <= '0;
      starved_q     <= 1'b1;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      audio_valid_q <= 1'b0;
      if (sample_tick) begin
        audio_valid_q <= 1'b1;
        if (starved_q) begin
          if (full_w) begin
            audio_out_q <= out_w;
            play_b_q    <= ~play_b_q;
            r_q         <= R_ONE;
            starved_q   <= 1'b0;
          end else begin
            audio_out_q <= silence_w;
            underrun_q  <= 1'b1;
          end
        end else begin
          audio_out_q <= out_w;
          if (r_q == R_LAST) begin
            r_q <= '0;
            if (full_w) begin
              play_b_q <= ~play_b_q;
            end else begin
              starved_q <= 1'b1;
            end
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
      end
    end
  end

  assign frame_ready = frame_ready_q;
  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign underrun    = underrun_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_ifft_overlap_add.sv
// tb/tb_ifft_overlap_add.sv - directed table-driven bench for ifft_overlap_add
module tb_ifft_overlap_add;

  localparam int N     = 512;
  localparam int HOP   = 256;
  localparam int NB    = 18;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             frame_valid = 1'b0;
  logic [NB-1:0]    frame_data = '0;
  logic [3:0]       frame_scaling = '0;
  logic             sample_tick = 1'b0;
  logic             frame_ready;
  logic [OUT_W-1:0] audio_out;
  logic             audio_valid;
  logic             underrun;
  logic             drop_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifft_overlap_add dut (
    .clk           (clk),
    .reset         (reset),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_scaling (frame_scaling),
    .frame_ready   (frame_ready),
    .sample_tick   (sample_tick),
    .audio_out     (audio_out),
    .audio_valid   (audio_valid),
    .underrun      (underrun),
    .drop_err      (drop_err)
  );

  typedef struct {
    logic [NB-1:0] data;
    logic [3:0]    sc;
    int            exp;
  } rec_t;

  rec_t tbl[8];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Starts and ends just after a negedge; tick spacing is 3 cycles.
  task automatic tick(output logic [OUT_W-1:0] v, output logic ok);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    v  = audio_out;
    ok = audio_valid;
    @(negedge clk);
    ok = ok && !audio_valid;
    @(negedge clk);
  endtask

  // mode 1: ramp data 4*k; otherwise constant d. Scaling is only correct on sample 0.
  task automatic send_frame(input int mode, input logic [NB-1:0] d, input logic [3:0] sc,
                            output int fr1);
    fr1 = -1;
    for (int k = 0; k < N; k++) begin
      frame_valid   = 1'b1;
      frame_data    = (mode == 1) ? NB'(4 * k) : d;
      frame_scaling = (k == 0) ? sc : ~sc;
      @(negedge clk);
      if (k == 0) fr1 = int'(frame_ready);
    end
    frame_valid = 1'b0;
  endtask

  // mode 1: expected sample j is (256+j)>>>2; otherwise constant c.
  task automatic play_hop(input string name, input int first, input int n,
                          input int mode, input int c);
    int nbad = 0;
    int g0 = 0;
    int w0 = 0;
    int got;
    int want;
    logic [OUT_W-1:0] v;
    logic ok;
    for (int j = first; j < first + n; j++) begin
      tick(v, ok);
      want = (mode == 1) ? (256 + j) / 4 : c;
      got  = $signed(v);
      if (!ok || got != want) begin
        if (nbad == 0) begin
          g0 = got;
          w0 = want;
        end
        nbad++;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s bad_samples=%0d first_got=%0d want=%0d", name, nbad, g0, w0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] v;
    logic ok;
    int fr;

    tbl[0] = '{18'd1024,  4'd0, 64};
    tbl[1] = '{18'd1024,  4'd0, 128};
    tbl[2] = '{18'h1FFFF, 4'd4, 32767};
    tbl[3] = '{18'h3FC00, 4'd0, 32703};
    tbl[4] = '{18'h20000, 4'd4, -32768};
    tbl[5] = '{18'd0,     4'd0, -32768};
    tbl[6] = '{18'd100,   4'd3, 50};
    tbl[7] = '{18'h3FFF9, 4'd0, 49};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_audio_out", $signed(audio_out), 0);
    check("rst_audio_valid", int'(audio_valid), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_drop_err", int'(drop_err), 0);
    check("rst_frame_ready", int'(frame_ready), 1);

    for (int t = 0; t < 3; t++) begin
      tick(v, ok);
      check("idle_tick_value", $signed(v), 0);
      check("idle_tick_valid", int'(ok), 1);
    end
    check("idle_underrun", int'(underrun), 1);

    for (int i = 0; i < 8; i++) begin
      send_frame(0, tbl[i].data, tbl[i].sc, fr);
      check($sformatf("frame%0d_ready_drop", i), fr, 0);
      if (i == 0) begin
        check("full_frame_ready", int'(frame_ready), 0);
        for (int p = 0; p < 3; p++) begin
          frame_valid = 1'b1;
          frame_data  = 18'h1FFFF;
          @(negedge clk);
        end
        frame_valid = 1'b0;
        check("drop_err_set", int'(drop_err), 1);
      end
      play_hop($sformatf("hop%0d", i), 0, HOP, 0, tbl[i].exp);
      check($sformatf("frame%0d_ready_after_swap", i), int'(frame_ready), 1);
    end

    // Reset in the middle of a frame
    for (int k = 0; k < 100; k++) begin
      frame_valid   = 1'b1;
      frame_data    = 18'd1024;
      frame_scaling = 4'd0;
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    check("midrst_audio_out", $signed(audio_out), 0);
    check("midrst_audio_valid", int'(audio_valid), 0);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_drop_err", int'(drop_err), 0);
    check("midrst_frame_ready", int'(frame_ready), 1);
    @(negedge clk);
    frame_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    send_frame(0, 18'd1024, 4'd0, fr);
    play_hop("post_reset_hop", 0, HOP, 0, 64);
    check("post_reset_underrun", int'(underrun), 0);

    // Ramp frame, then the next frame streams while the ramp hop plays
    send_frame(1, '0, 4'd0, fr);
    play_hop("ramp_first", 0, 1, 1, 0);
    fork
      play_hop("ramp_hop", 1, HOP - 1, 1, 0);
      send_frame(0, 18'd0, 4'd0, fr);
    join
    play_hop("tail_hop", 0, HOP, 1, 0);
    check("overlap_underrun", int'(underrun), 0);
    check("overlap_drop_err", int'(drop_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
